// File: rtl/aes128_compactor_pkg.sv
// Shared definitions for the aes128 result compactor.
//   MISR_POLY_128 : feedback taps of x^128+x^7+x^2+x+1 (low-order constant only)
//   state_t       : serializer FSM states; HDR is present in every build so
//                   the type does not change with the epoch-tag option
//   beats()       : number of OUT_W-bit beats needed to carry one signature
package aes128_compactor_pkg;

  localparam logic [127:0] MISR_POLY_128 = 128'h87;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic int beats(input int width, input int out_w);
    return width / out_w;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register.
//   clk      : clock
//   reset    : asynchronous active-low reset, clears the signature
//   en       : absorb din this cycle
//   clr      : when en is also high, load zero instead of sig_next
//   din      : word to fold into the signature
//   sig      : current signature
//   sig_next : signature after folding din in (valid whether or not en is high)
module misr_reg
  import aes128_compactor_pkg::*;
#(
  parameter int               WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_128)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  // Galois-style shift: the bit falling off the top folds back through POLY.
  always_comb begin
    sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig <= '0;
    end else if (en) begin
      sig <= clr ? '0 : sig_next;
    end
  end

endmodule

// File: rtl/aes128_result_compactor.sv
// Compresses a stream of ciphertext words into a MISR signature and, every
// INTERVAL accepted words, streams the signature out OUT_W bits per beat,
// most significant chunk first, over a valid/ready handshake.
// Optional build macro COMPACTOR_EPOCH_TAG_EN: each signature is preceded by a
// header beat carrying an OUT_W-bit epoch number.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   din       : ciphertext word
//   din_valid : din qualifies this cycle (no upstream backpressure)
//   sig_data  : signature beat (zero while sig_valid is low)
//   sig_valid : beat valid
//   sig_ready : sink accepts the beat
//   sig_last  : final beat of a signature
//   overrun   : sticky, a snapshot was dropped because the serializer was busy
module aes128_result_compactor
  import aes128_compactor_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int OUT_W    = 8,
  parameter int INTERVAL = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] sig_data,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic             sig_last,
  output logic             overrun
);

  localparam int NBEATS = beats(WIDTH, OUT_W);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CW     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]    beat_reg, beat_next;
  logic [CW-1:0]    count_reg;
  logic             overrun_reg;
  logic [WIDTH-1:0] snapshot;
  logic             epoch_end, last_beat, last_hs, accept;

  // Epoch boundary: the valid word that completes INTERVAL words.
  assign epoch_end = din_valid && (count_reg == CW'(INTERVAL - 1));
  assign last_beat = (state_reg == SEND) && (beat_reg == BW'(NBEATS - 1));
  assign last_hs   = last_beat && sig_ready;
  // A busy serializer can still take a snapshot if its final beat leaves
  // on this very edge, which lets signatures run back to back.
  assign accept    = epoch_end && ((state_reg == IDLE) || last_hs);

  // The sig port is not needed here: the snapshot is the post-update value.
  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (WIDTH'(MISR_POLY_128))
  ) u_misr (
    .clk      (clk),
    .reset    (reset),
    .en       (din_valid),
    .clr      (epoch_end),
    .din      (din),
    .sig      (),
    .sig_next (snapshot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (din_valid) begin
      count_reg <= epoch_end ? '0 : count_reg + CW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: ;
      HDR: begin
        if (sig_ready) state_next = SEND;
      end
      SEND: begin
        if (sig_ready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            shift_next = shift_reg << OUT_W;
            beat_next  = beat_reg + BW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      shift_next = snapshot;
      beat_next  = '0;
`ifdef COMPACTOR_EPOCH_TAG_EN
      state_next = HDR;
`else
      state_next = SEND;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      beat_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      beat_reg    <= beat_next;
      overrun_reg <= overrun_reg | (epoch_end & ~accept);
    end
  end

`ifdef COMPACTOR_EPOCH_TAG_EN
  // Counts emitted signatures only; dropped snapshots never reach last_hs.
  logic [OUT_W-1:0] epoch_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epoch_reg <= '0;
    end else if (last_hs) begin
      epoch_reg <= epoch_reg + OUT_W'(1);
    end
  end
`endif

  always_comb begin
    sig_valid = 1'b0;
    sig_data  = '0;
    sig_last  = 1'b0;
    case (state_reg)
      SEND: begin
        sig_valid = 1'b1;
        sig_data  = shift_reg[WIDTH-1 -: OUT_W];
        sig_last  = (beat_reg == BW'(NBEATS - 1));
      end
`ifdef COMPACTOR_EPOCH_TAG_EN
      HDR: begin
        sig_valid = 1'b1;
        sig_data  = epoch_reg;
      end
`endif
      default: ;
    endcase
  end

  assign overrun = overrun_reg;

endmodule

// File: tb/tb_aes128_result_compactor.sv
module tb_aes128_result_compactor;

  localparam int NB = 16;
`ifdef COMPACTOR_EPOCH_TAG_EN
  localparam int TAG = 1;
`else
  localparam int TAG = 0;
`endif
  localparam int SB = NB + TAG;   // beats per signature including any header

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din;
  logic         din_valid;
  logic         sig_ready;
  logic [7:0]   sd [4];
  logic         sv [4];
  logic         sl [4];
  logic         ov [4];

  int total = 0;
  int bad   = 0;
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  logic [7:0] hold_q[$];
  int first_cyc;
  int gap_cnt;

  always #5 clk = ~clk;

  // Instance index -> INTERVAL: 0->1, 1->2, 2->4, 3->16
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    aes128_result_compactor #(
      .WIDTH    (128),
      .OUT_W    (8),
      .INTERVAL ((gi == 3) ? 16 : (1 << gi))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .sig_data  (sd[gi]),
      .sig_valid (sv[gi]),
      .sig_ready (sig_ready),
      .sig_last  (sl[gi]),
      .overrun   (ov[gi])
    );
  end

  task automatic apply_reset();
    din_valid = 1'b0;
    din       = '0;
    sig_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic drive_word(input logic [127:0] d);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din       = '0;
  endtask

  // Drives sig_ready and records accepted beats of instance idx.
  task automatic collect(input int idx, input int n, input int stall_at,
                         input int stall_len, input int budget);
    int cyc = 0;
    int stalled = 0;
    got_q.delete();
    got_last_q.delete();
    hold_q.delete();
    first_cyc = -1;
    gap_cnt = 0;
    while (got_q.size() < n && cyc < budget) begin
      sig_ready = 1'b1;
      if (sv[idx] && got_q.size() == stall_at && stalled < stall_len) begin
        sig_ready = 1'b0;
        stalled++;
      end
      if (sv[idx]) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (sig_ready) begin
          got_q.push_back(sd[idx]);
          got_last_q.push_back(sl[idx]);
        end else begin
          hold_q.push_back(sd[idx]);
        end
      end else if (first_cyc >= 0) begin
        gap_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    sig_ready = 1'b1;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din       = {4{32'hdeadbeef}} ^ 128'(i);
      din_valid = ~din_valid;
      @(negedge clk);
    end
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sv[k] !== 1'b0 || sd[k] !== 8'h00 || ov[k] !== 1'b0 || sl[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: valid=%b data=%h overrun=%b last=%b required 0", k, sv[k], sd[k], ov[k], sl[k]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    drive_word(128'h1);
    total++;
    if (sv[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_valid: valid=%b required 1", sv[0]);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (sv[0] !== 1'b0 || sd[0] !== 8'h00 || sl[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: valid=%b data=%h last=%b required 0", sv[0], sd[0], sl[0]);
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_single_word();
    logic [7:0] exp_d;
    apply_reset();
    sig_ready = 1'b1;
    drive_word(128'h1);
    collect(0, SB, -1, 0, 100);
    total++;
    if (got_q.size() != SB || first_cyc != 0) begin
      bad++;
      $display("FAIL single_count: beats=%0d first=%0d required %0d/0", got_q.size(), first_cyc, SB);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      exp_d = (i - TAG == 15) ? 8'h01 : 8'h00;
      total++;
      if (got_q[i] !== exp_d || got_last_q[i] !== (i == SB - 1)) begin
        bad++;
        $display("FAIL single_beat[%0d]: data=%h last=%b required %h/%b", i, got_q[i], got_last_q[i], exp_d, (i == SB - 1));
      end
    end
    total++;
    if (sv[0] !== 1'b0 || sd[0] !== 8'h00) begin
      bad++;
      $display("FAIL single_after: valid=%b data=%h required 0/00", sv[0], sd[0]);
    end
  endtask

  task automatic test_feedback();
    logic [7:0] exp_d;
    apply_reset();
    sig_ready = 1'b1;
    drive_word({1'b1, 127'b0});
    drive_word(128'h0);
    collect(1, SB, -1, 0, 100);
    total++;
    if (got_q.size() != SB) begin
      bad++;
      $display("FAIL feedback_count: beats=%0d required %0d", got_q.size(), SB);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      exp_d = (i - TAG == 15) ? 8'h87 : 8'h00;
      total++;
      if (got_q[i] !== exp_d || got_last_q[i] !== (i == SB - 1)) begin
        bad++;
        $display("FAIL feedback_beat[%0d]: data=%h last=%b required %h/%b", i, got_q[i], got_last_q[i], exp_d, (i == SB - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    apply_reset();
    sig_ready = 1'b1;
    drive_word(128'h0102030405060708090a0b0c0d0e0f10);
    collect(0, SB, 4 + TAG, 5, 100);
    total++;
    if (got_q.size() != SB || hold_q.size() != 5) begin
      bad++;
      $display("FAIL bp_count: beats=%0d stalls=%0d required %0d/5", got_q.size(), hold_q.size(), SB);
    end
    for (int i = 0; i < hold_q.size(); i++) begin
      total++;
      if (hold_q[i] !== 8'h05) begin
        bad++;
        $display("FAIL bp_hold[%0d]: data=%h required 05", i, hold_q[i]);
      end
    end
    for (int i = 0; i < got_q.size(); i++) begin
      exp_d = (i < TAG) ? 8'h00 : 8'(i - TAG + 1);
      total++;
      if (got_q[i] !== exp_d || got_last_q[i] !== (i == SB - 1)) begin
        bad++;
        $display("FAIL bp_beat[%0d]: data=%h last=%b required %h/%b", i, got_q[i], got_last_q[i], exp_d, (i == SB - 1));
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    sig_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_word(128'(i + 1));
    total++;
    if (ov[2] !== 1'b0 || sv[2] !== 1'b1 || sd[2] !== 8'h00) begin
      bad++;
      $display("FAIL ovr_first: overrun=%b valid=%b data=%h required 0/1/00", ov[2], sv[2], sd[2]);
    end
    for (int i = 4; i < 8; i++) drive_word(128'(i + 1));
    total++;
    if (ov[2] !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: overrun=%b required 1", ov[2]);
    end
    repeat (3) @(negedge clk);
    total++;
    if (ov[2] !== 1'b1 || sv[2] !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: overrun=%b valid=%b required 1/1", ov[2], sv[2]);
    end
    collect(2, SB, -1, 0, 100);
    total++;
    if (got_q.size() != SB || got_q[SB - 1] !== 8'h02) begin
      bad++;
      $display("FAIL ovr_sig: beats=%0d lastdata=%h required %0d/02", got_q.size(), (got_q.size() == SB) ? got_q[SB - 1] : 8'hxx, SB);
    end
    repeat (4) @(negedge clk);
    total++;
    if (sv[2] !== 1'b0 || ov[2] !== 1'b1) begin
      bad++;
      $display("FAIL ovr_dropped: valid=%b overrun=%b required 0/1", sv[2], ov[2]);
    end
    apply_reset();
    total++;
    if (ov[2] !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear: overrun=%b required 0", ov[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    int j;
    apply_reset();
    fork
      begin
        for (int e = 0; e < 2; e++) begin
          for (int w = 0; w < 16; w++) begin
            din       = (w == 0) ? ((e == 1) ? 128'h3 : 128'h1) : 128'h0;
            din_valid = 1'b1;
            @(negedge clk);
          end
          if (TAG == 1 && e == 0) begin
            din_valid = 1'b0;
            @(negedge clk);
          end
        end
        din_valid = 1'b0;
        din       = '0;
      end
      collect(3, 2 * SB, -1, 0, 200);
    join
    total++;
    if (got_q.size() != 2 * SB || gap_cnt != 0) begin
      bad++;
      $display("FAIL b2b_count: beats=%0d gaps=%0d required %0d/0", got_q.size(), gap_cnt, 2 * SB);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      j = (i % SB) - TAG;
      if (j < 0) exp_d = 8'(i / SB);
      else if (j == 14) exp_d = 8'h80;
      else if (j == 13 && i >= SB) exp_d = 8'h01;
      else exp_d = 8'h00;
      total++;
      if (got_q[i] !== exp_d || got_last_q[i] !== ((i % SB) == SB - 1)) begin
        bad++;
        $display("FAIL b2b_beat[%0d]: data=%h last=%b required %h/%b", i, got_q[i], got_last_q[i], exp_d, ((i % SB) == SB - 1));
      end
    end
  endtask

  task automatic test_epoch_tag();
    int nlast;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      sig_ready = 1'b1;
      drive_word(128'(s + 1));
      collect(0, SB, -1, 0, 100);
      nlast = 0;
      foreach (got_last_q[i]) if (got_last_q[i] === 1'b1) nlast++;
      total++;
      if (got_q.size() != SB || got_q[0] !== ((TAG == 1) ? 8'(s) : 8'h00) ||
          got_q[SB - 1] !== 8'(s + 1) || nlast != 1 || got_last_q[SB - 1] !== 1'b1) begin
        bad++;
        $display("FAIL epoch_sig[%0d]: beats=%0d first=%h lastdata=%h lastflags=%0d required %0d/%h/%h/1",
                 s, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx,
                 (got_q.size() == SB) ? got_q[SB - 1] : 8'hxx, nlast, SB,
                 (TAG == 1) ? 8'(s) : 8'h00, 8'(s + 1));
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sig_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_feedback();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_epoch_tag();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/aes128_result_compactor.md
Name: aes128_result_compactor

Overview:
- Downstream consumer of the aes128 core's 128-bit ciphertext in out-of-context builds.
- Compresses each valid ciphertext into a multiple-input signature register (MISR).
- Every INTERVAL accepted words, it snapshots the signature and streams it out narrow (OUT_W bits/beat) over a valid/ready handshake.
- This keeps the full AES datapath live while the block exposes only a few top-level pins.

Parameters:
- WIDTH, 128, MISR/input width; must be a multiple of OUT_W.
- OUT_W, 8, output beat width.
- INTERVAL, 1024, accepted input words per signature epoch; must be >= 1.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while reset=0.
- din  input  WIDTH  ciphertext from aes128.
- din_valid  input  1  din qualifies this cycle; there is no backpressure upstream.
- sig_data  output  OUT_W  serialized signature beat, MSB chunk first.
- sig_valid  output  1  beat valid.
- sig_ready  input  1  sink accepts the beat.
- sig_last  output  1  final beat of a signature.
- overrun  output  1  sticky flag: a snapshot was dropped.

Behaviour:
- Reset, asynchronous and immediate:
  - MISR=0, sample count=0, FSM=IDLE, shift buffer=0.
  - sig_valid=0, sig_data=0, sig_last=0, overrun=0.
  - Reset mid-transfer abandons the transfer with no partial-state retention.
- MISR update on a cycle with din_valid=1:
  - sig_next = (sig<<1) ^ (sig[WIDTH-1] ? MISR_POLY : 0) ^ din.
  - MISR_POLY is x^128+x^7+x^2+x+1, i.e. the low-order constant 'h87, zero-extended.
  - With din_valid=0 the MISR holds.
- Epoch counting:
  - The count increments on each valid word.
  - On the valid word where count==INTERVAL-1:
    - snapshot = sig_next;
    - the MISR loads 0, so the next epoch starts clean;
    - count wraps to 0.
- Snapshot accept:
  - A snapshot is taken if the FSM is IDLE, or if the last beat handshakes in that same cycle.
  - Otherwise the snapshot is dropped and overrun is set to 1 until reset. The MISR is still cleared.
- FSM states IDLE and SEND:
  - IDLE -> SEND on snapshot accept; the buffer loads and beat count=0.
  - In SEND: sig_valid=1, sig_data=buf[WIDTH-1 -: OUT_W], sig_last=(beat==WIDTH/OUT_W-1).
  - On sig_valid&&sig_ready: buffer shifts left by OUT_W and beat increments.
  - After the last beat, the FSM returns to IDLE, or reloads and stays in SEND if a snapshot arrives in the same cycle.
- Latency: sig_valid rises one cycle after the clock edge that captures the snapshot.
- Handshake rules:
  - While sig_valid&&!sig_ready, sig_data and sig_last hold stable.
  - sig_valid never drops before its beat is accepted.
  - sig_data=0 when sig_valid=0.
- INTERVAL=1: every valid word is its own epoch, and snapshot = din ^ 0.

Optional Feature:
- Macro: COMPACTOR_EPOCH_TAG_EN.
- Defined:
  - Each signature is preceded by one header beat carrying an OUT_W-bit epoch number.
  - The epoch number resets to 0 and increments after each emitted signature; dropped snapshots do not increment it. It wraps at 2^OUT_W.
  - The FSM gains a HDR state: IDLE -> HDR -> SEND.
  - sig_last=0 on the header beat.
  - The same-cycle reload after the last beat goes to HDR.
- Undefined: no header, no epoch counter logic, exactly WIDTH/OUT_W beats per signature.

Decomposition:
- Package aes128_compactor_pkg holds:
  - MISR_POLY_128;
  - typedef enum for the FSM states (HDR always declared);
  - a function beats(WIDTH, OUT_W).
- One sub-module, misr_reg (parameterised WIDTH, POLY; clk, async active-low reset, en, clr, din, sig, sig_next).
- The serializer FSM stays in the top.

Test Plan:
1. Reset: hold reset=0 with din_valid toggling -> sig_valid=0, sig_data=0, overrun=0. Assert reset asynchronously between edges -> outputs 0 before the next clk edge.
2. INTERVAL=1, din=128'h1 for one cycle, sig_ready=1 -> 16 beats starting the next cycle: 15×8'h00, then 8'h01 with sig_last=1; then sig_valid=0.
3. Feedback: INTERVAL=2, din=128'h8000…0 then 128'h0 -> signature 128'h87 -> beats 15×8'h00 then 8'h87 (last).
4. Backpressure: INTERVAL=1, din=128'h0102…10, sig_ready low for 5 cycles at beat 4 -> sig_data holds 8'h05 stably. The full sequence 8'h01…8'h10 arrives with no loss or duplication.
5. Overrun and back-to-back:
   - INTERVAL=4, sig_ready=0, 8 consecutive valid words -> second snapshot dropped, overrun=1 held until reset.
   - Separately, INTERVAL=16 with ready=1 -> the next signature starts immediately after sig_last, with no idle gap.
6. COMPACTOR_EPOCH_TAG_EN, INTERVAL=1, two words -> beat sequences [8'h00, 16 data] then [8'h01, 16 data]. sig_last appears only on the 17th beat of each.
